// File: rtl/serial_pattern_detector_pkg.sv
// rtl/serial_pattern_detector_pkg.sv - types and defaults shared by the detector and its bench
package serial_pattern_detector_pkg;

  `include "seq_det_defs.vh"

  typedef enum logic {
    STATE_FILL  = ST_FILL,
    STATE_ARMED = ST_ARMED
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, clear has priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_defs.vh
// rtl/seq_det_defs.vh - shared FSM encodings and default parameters for the serial pattern detector
`ifndef SEQ_DET_DEFS_VH
`define SEQ_DET_DEFS_VH

localparam logic       ST_FILL     = 1'b0;
localparam logic       ST_ARMED    = 1'b1;
localparam int         DEF_LEN     = 4;
localparam logic [3:0] DEF_PATTERN = 4'b1011;
localparam int         DEF_CNT_W   = 8;

`endif

// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - serial LEN-bit pattern detector with saturating match count
// SEQ_OVERLAP_EN defined: overlapping detection; undefined: each match consumes the window.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN-1:0]   hist,
  output logic             armed
);

  localparam int             FW     = $clog2(LEN + 1);
  localparam logic [FW-1:0] LEN_F  = FW'(LEN);
  localparam logic [FW-1:0] LEN_M1 = FW'(LEN - 1);

  state_t           state, state_nxt;
  logic [FW-1:0]    fill, fill_nxt, fill_inc;
  logic [LEN-1:0]   hist_nxt, nh;
  logic             match_nxt;

  assign nh       = {hist[LEN-2:0], d};
  assign fill_inc = (fill == LEN_F) ? fill : fill + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STATE_FILL;
      fill  <= '0;
      hist  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      hist  <= hist_nxt;
      match <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    hist_nxt  = hist;
    match_nxt = 1'b0;
    if (en) begin
      hist_nxt  = nh;
      fill_nxt  = fill_inc;
      // fill >= LEN-1 means this bit completes a full window
      match_nxt = (fill >= LEN_M1) && (nh == PATTERN);
      case (state)
        STATE_FILL:  if (fill_inc == LEN_F) state_nxt = STATE_ARMED;
        STATE_ARMED: state_nxt = STATE_ARMED;
        default:     state_nxt = STATE_FILL;
      endcase
`ifndef SEQ_OVERLAP_EN
      if (match_nxt) begin
        fill_nxt  = '0;
        state_nxt = STATE_FILL;
      end
`endif
    end
  end

  assign armed = (state == STATE_ARMED);

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (match_nxt),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - self-checking bench for serial_pattern_detector
module tb_serial_pattern_detector;
  import serial_pattern_detector_pkg::*;

  localparam int LEN = DEF_LEN;
  localparam logic [LEN-1:0] PAT = DEF_PATTERN;
`ifdef SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, d = 1'b0, clr_cnt = 1'b0;
  logic match, match2, armed, armed2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [LEN-1:0] hist, hist2;

  int total = 0;
  int bad = 0;
  int m_hist = 0, m_fill = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_match = 1'b0;
  int pulses;

  always #5 clk = ~clk;

  serial_pattern_detector dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr_cnt(clr_cnt),
    .match(match), .match_cnt(match_cnt), .hist(hist), .armed(armed)
  );

  serial_pattern_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .d(d), .clr_cnt(clr_cnt),
    .match(match2), .match_cnt(match_cnt2), .hist(hist2), .armed(armed2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic dd, input logic c);
    int nh;
    bit hit;
    rst = r; en = e; d = dd; clr_cnt = c;
    @(posedge clk);
    if (r) begin
      m_hist = 0; m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_match = 1'b0;
    end else begin
      hit = 1'b0;
      if (e) begin
        nh  = ((m_hist * 2) + int'(dd)) % (1 << LEN);
        hit = (m_fill + 1 >= LEN) && (nh == int'(PAT));
        m_hist = nh;
        m_fill = (m_fill + 1 > LEN) ? LEN : m_fill + 1;
        if (hit && !OVERLAP) m_fill = 0;
      end
      m_match = hit;
      if (c) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (hit) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
      end
    end
    #1;
    chk("model_match", 32'(match), 32'(m_match));
    chk("model_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("model_cnt2", 32'(match_cnt2), 32'(m_cnt2));
    chk("model_hist", 32'(hist), 32'(m_hist));
    chk("model_armed", 32'(armed), 32'(m_fill == LEN));
    chk("model_match2", 32'(match2), 32'(m_match));
    if (match) pulses++;
  endtask

  typedef struct {
    logic       rst, en, d, clr;
    logic       exp_m;
    int         exp_c;
    logic [3:0] exp_h;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int sat_exp[5];
    int prev;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0001};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0010};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0101};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b1011};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 4'b1011};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0001};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0010};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0101};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0001};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0010};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0101};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b1011};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 4'b0111};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4'b1110};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 4'b1101};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b1011};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0111};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b1110};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b1101};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b1011};
    sat_exp = '{1, 2, 3, 3, 3};
    pulses = 0;

    @(negedge clk);
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl%0d_match", i), 32'(match), 32'(tbl[i].exp_m));
      chk($sformatf("tbl%0d_cnt", i), 32'(match_cnt), 32'(tbl[i].exp_c));
      chk($sformatf("tbl%0d_hist", i), 32'(hist), 32'(tbl[i].exp_h));
    end
    chk("reset_armed_after_tbl0", 32'(armed), 32'(m_fill == LEN));

    // 1011011: overlap mode reuses the trailing 1 of the first match
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_armed", 32'(armed), 32'd0);
    pulses = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovl_armed_bit4", 32'(armed), OVERLAP ? 32'd1 : 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovl_match_bit7", 32'(match), OVERLAP ? 32'd1 : 32'd0);
    chk("ovl_pulses", 32'(pulses), OVERLAP ? 32'd2 : 32'd1);
    chk("ovl_cnt", 32'(match_cnt), OVERLAP ? 32'd2 : 32'd1);

    // en gap between bits 2 and 3 with d toggling
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, ~i[0], 1'b0);
      chk($sformatf("gap%0d_hist", i), 32'(hist), 32'b0010);
      chk($sformatf("gap%0d_match", i), 32'(match), 32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("gap_match", 32'(match), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_pulse_end", 32'(match), 32'd0);
    chk("gap_pulses", 32'(pulses), 32'd1);

    // saturation of the 2-bit counter
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("sat%0d_cnt2", p), 32'(match_cnt2), 32'(sat_exp[p]));
      chk($sformatf("sat%0d_match2", p), 32'(match2), 32'd1);
    end
    chk("sat_pulses", 32'(pulses), 32'd5);
    chk("sat_cnt8", 32'(match_cnt), 32'd5);

    // randomized traffic against the reference model
    prev = pulses;
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 19) == 0));
    end
    if (pulses == prev) begin
      total++; bad++;
      $display("FAIL rand_no_matches: got 0 pulses expected >0");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
